// File: rtl/fsm_lab2.sv
// Flash-audio playback controller: fetches 32-bit flash words, plays the upper
// byte of each 16-bit sample on 22 kHz strobes, steered by ASCII key codes.
module fsm_lab2 #(
  parameter logic [22:0] START_ADDR   = 23'h000000,
  parameter logic [22:0] END_ADDR     = 23'h07FFFF,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sync_22KHz_pulse,
  input  logic [7:0]  kbdinput,
  input  logic [31:0] flash_mem_readdata,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  output logic [7:0]  audio_data
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_READ,
    S_WAIT,
    S_CAPTURE,
    S_PHASE0,
    S_PHASE1
  } state_t;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_BWD = 1'b1
  } dir_t;

  localparam logic [7:0] KEY_PLAY    = 8'h45;  // 'E'
  localparam logic [7:0] KEY_PAUSE   = 8'h44;  // 'D'
  localparam logic [7:0] KEY_FWD     = 8'h46;  // 'F'
  localparam logic [7:0] KEY_BWD     = 8'h42;  // 'B'
  localparam logic [7:0] KEY_RESTART = 8'h52;  // 'R'

  localparam int WAIT_CYCLES = READ_LATENCY - 1;

  state_t      state, next_state;
  dir_t        direction;
  dir_t        word_dir;
  logic        playing;
  logic [1:0]  wait_cnt;
  logic [7:0]  hi_byte;
  logic [7:0]  lo_byte;
  logic [22:0] next_addr;

  logic key_play, key_pause, key_fwd, key_bwd, key_restart;
  logic pulse_ok;
  logic load_word, emit_first, emit_second, latch_dir;

  // Only the upper byte of each sample is ever played.
  logic unused_readdata;
  assign unused_readdata = ^{flash_mem_readdata[23:16], flash_mem_readdata[7:0]};

  assign key_play    = (kbdinput == KEY_PLAY);
  assign key_pause   = (kbdinput == KEY_PAUSE);
  assign key_fwd     = (kbdinput == KEY_FWD);
  assign key_bwd     = (kbdinput == KEY_BWD);
  assign key_restart = (kbdinput == KEY_RESTART);
  assign pulse_ok    = sync_22KHz_pulse && playing;

  assign flash_mem_read = (state == S_READ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next_state;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    next_state  = state;
    load_word   = 1'b0;
    emit_first  = 1'b0;
    emit_second = 1'b0;
    latch_dir   = 1'b0;
    if (key_restart) begin
      next_state = S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          if (playing) begin
            next_state = S_READ;
            latch_dir  = 1'b1;
          end
        end
        S_READ:    next_state = (WAIT_CYCLES == 0) ? S_CAPTURE : S_WAIT;
        S_WAIT: begin
          if (int'(wait_cnt) + 1 >= WAIT_CYCLES) next_state = S_CAPTURE;
        end
        S_CAPTURE: begin
          load_word  = 1'b1;
          next_state = S_PHASE0;
        end
        S_PHASE0: begin
          if (pulse_ok) begin
            emit_first = 1'b1;
            next_state = S_PHASE1;
          end
        end
        S_PHASE1: begin
          if (pulse_ok) begin
            emit_second = 1'b1;
            next_state  = S_FETCH;
          end
        end
        default:   next_state = S_FETCH;
      endcase
    end
  end

  // The address steps in the direction the current word was fetched with.
  always_comb begin
    next_addr = flash_mem_address;
    if (word_dir == DIR_FWD)
      next_addr = (flash_mem_address == END_ADDR) ? START_ADDR : flash_mem_address + 23'd1;
    else
      next_addr = (flash_mem_address == START_ADDR) ? END_ADDR : flash_mem_address - 23'd1;
  end

  // NOTE: the sample-word register is tiny, so it is reset along with the rest
  // of the state rather than left undefined until the first capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_mem_address <= START_ADDR;
      audio_data        <= 8'h00;
      playing           <= 1'b0;
      direction         <= DIR_FWD;
      word_dir          <= DIR_FWD;
      wait_cnt          <= 2'd0;
      hi_byte           <= 8'h00;
      lo_byte           <= 8'h00;
    end else begin
      if (key_play)       playing <= 1'b1;
      else if (key_pause) playing <= 1'b0;

      if (key_fwd)      direction <= DIR_FWD;
      else if (key_bwd) direction <= DIR_BWD;

      if (latch_dir) word_dir <= direction;

      if (state == S_READ)      wait_cnt <= 2'd0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 2'd1;

      if (load_word) begin
        hi_byte <= flash_mem_readdata[31:24];
        lo_byte <= flash_mem_readdata[15:8];
      end

      if (emit_first)  audio_data <= (word_dir == DIR_FWD) ? lo_byte : hi_byte;
      if (emit_second) audio_data <= (word_dir == DIR_FWD) ? hi_byte : lo_byte;

      if (key_restart)
        flash_mem_address <= (direction == DIR_FWD) ? START_ADDR : END_ADDR;
      else if (emit_second)
        flash_mem_address <= next_addr;
    end
  end

endmodule

// File: tb/tb_fsm_lab2.sv
// Directed bench for fsm_lab2: play, pause, direction, restart, wraparound,
// key/pulse conflicts and reset during a read.
module tb_fsm_lab2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sync_22KHz_pulse;
  logic [7:0]  kbdinput;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic [7:0]  audio_data;

  int checks = 0;
  int passed = 0;

  int          read_cnt = 0;
  logic [22:0] last_read_addr = '0;
  logic        prev_read = 1'b0;
  logic        double_read = 1'b0;
  int          snap_cnt;

  always #5 clk = ~clk;

  fsm_lab2 dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .sync_22KHz_pulse   (sync_22KHz_pulse),
    .kbdinput           (kbdinput),
    .flash_mem_readdata (flash_mem_readdata),
    .flash_mem_read     (flash_mem_read),
    .flash_mem_address  (flash_mem_address),
    .audio_data         (audio_data)
  );

  // Read-strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (flash_mem_read) begin
      read_cnt++;
      last_read_addr = flash_mem_address;
      if (prev_read) double_read = 1'b1;
    end
    prev_read = flash_mem_read;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic key(input logic [7:0] code);
    kbdinput = code;
    step(1);
    kbdinput = 8'h00;
  endtask

  task automatic pulse(input logic [7:0] code = 8'h00);
    kbdinput = code;
    sync_22KHz_pulse = 1'b1;
    step(1);
    sync_22KHz_pulse = 1'b0;
    kbdinput = 8'h00;
  endtask

  initial begin
    reset_n = 1'b0;
    sync_22KHz_pulse = 1'b0;
    kbdinput = 8'h00;
    flash_mem_readdata = 32'hAABBCCDD;
    step(2);
    check("rst_audio", {24'd0, audio_data}, 32'h00);
    check("rst_addr", {9'd0, flash_mem_address}, 32'h0);
    check("rst_read", {31'd0, flash_mem_read}, 32'h0);

    // Idle after release: no key, nothing fetched.
    reset_n = 1'b1;
    step(5);
    check("idle_reads", read_cnt, 0);
    check("idle_audio", {24'd0, audio_data}, 32'h00);
    check("idle_addr", {9'd0, flash_mem_address}, 32'h0);

    // Forward play of 32'hAABBCCDD at address 0.
    key(8'h45);
    step(4);
    check("fwd_reads", read_cnt, 1);
    check("fwd_rd_addr", {9'd0, last_read_addr}, 32'h0);
    pulse();
    check("fwd_byte0", {24'd0, audio_data}, 32'hCC);
    step(4);
    check("fwd_hold", {24'd0, audio_data}, 32'hCC);
    flash_mem_readdata = 32'h12345678;
    pulse();
    check("fwd_byte1", {24'd0, audio_data}, 32'hAA);
    check("fwd_addr", {9'd0, flash_mem_address}, 32'h1);
    check("fwd_one_read", read_cnt, 1);

    // Next word at address 1, then pause mid-word.
    step(4);
    check("w1_reads", read_cnt, 2);
    check("w1_rd_addr", {9'd0, last_read_addr}, 32'h1);
    pulse();
    check("w1_byte0", {24'd0, audio_data}, 32'h56);
    key(8'h44);
    for (int p = 0; p < 3; p++) begin
      pulse();
      step(4);
    end
    check("pause_audio", {24'd0, audio_data}, 32'h56);
    check("pause_reads", read_cnt, 2);
    check("pause_addr", {9'd0, flash_mem_address}, 32'h1);
    key(8'h45);
    step(1);
    pulse();
    check("resume_byte1", {24'd0, audio_data}, 32'h12);
    check("resume_addr", {9'd0, flash_mem_address}, 32'h2);

    // Backward with restart.
    flash_mem_readdata = 32'h11223344;
    key(8'h42);
    key(8'h52);
    check("bwd_restart_addr", {9'd0, flash_mem_address}, 32'h7FFFF);
    step(4);
    check("bwd_rd_addr", {9'd0, last_read_addr}, 32'h7FFFF);
    pulse();
    check("bwd_byte0", {24'd0, audio_data}, 32'h11);
    step(4);
    pulse();
    check("bwd_byte1", {24'd0, audio_data}, 32'h33);
    check("bwd_addr", {9'd0, flash_mem_address}, 32'h7FFFE);

    // Forward at END_ADDR wraps to START_ADDR.
    key(8'h44);
    step(3);
    key(8'h52);
    check("restart_bwd_end", {9'd0, flash_mem_address}, 32'h7FFFF);
    key(8'h46);
    key(8'h45);
    step(4);
    check("wrapf_rd_addr", {9'd0, last_read_addr}, 32'h7FFFF);
    pulse();
    check("wrapf_byte0", {24'd0, audio_data}, 32'h33);
    step(4);
    pulse(8'h42);
    check("wrapf_byte1", {24'd0, audio_data}, 32'h11);
    check("wrapf_addr", {9'd0, flash_mem_address}, 32'h0);

    // Backward at START_ADDR wraps to END_ADDR.
    flash_mem_readdata = 32'h55667788;
    step(4);
    check("wrapb_rd_addr", {9'd0, last_read_addr}, 32'h0);
    pulse();
    check("wrapb_byte0", {24'd0, audio_data}, 32'h55);
    step(4);
    pulse();
    check("wrapb_byte1", {24'd0, audio_data}, 32'h77);
    check("wrapb_addr", {9'd0, flash_mem_address}, 32'h7FFFF);

    // Restart on the same clk as a qualifying pulse: no byte, address reset.
    flash_mem_readdata = 32'hCAFEBABE;
    step(4);
    pulse();
    check("conf_byte0", {24'd0, audio_data}, 32'hCA);
    key(8'h46);
    step(3);
    pulse(8'h52);
    check("conf_audio", {24'd0, audio_data}, 32'hCA);
    check("conf_addr", {9'd0, flash_mem_address}, 32'h0);

    // Reset asserted during READ.
    step(1);
    check("mid_read_high", {31'd0, flash_mem_read}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_read", {31'd0, flash_mem_read}, 32'h0);
    check("rst_mid_audio", {24'd0, audio_data}, 32'h00);
    check("rst_mid_addr", {9'd0, flash_mem_address}, 32'h0);
    step(2);
    reset_n = 1'b1;
    snap_cnt = read_cnt;
    step(5);
    check("post_rst_paused", read_cnt, snap_cnt);
    check("no_double_read", {31'd0, double_read}, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
